// File: rtl/instr_encoder_if.sv
// Field-set input bus and encoded-word output bus of instr_encoder.
// The encoder connects through the slave modport, the producer/consumer through master.
interface instr_encoder_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [4:0]       shamt;
    logic [15:0]      imm;
    logic [25:0]      addr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      instr;
    logic [1:0]       fmt;
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid, opcode, funct, rs, rt, rd, shamt, imm, addr, out_ready,
        input  in_ready, out_valid, instr, fmt, count
    );

    modport slave (
        input  in_valid, opcode, funct, rs, rt, rd, shamt, imm, addr, out_ready,
        output in_ready, out_valid, instr, fmt, count
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs R/I/J instruction fields into 32-bit words, buffers them in a
// DEPTH-entry FIFO and counts the words handed to the consumer.
module instr_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_encoder_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        FMT_R = 2'b00,
        FMT_I = 2'b01,
        FMT_J = 2'b10
    } fmt_e;

    typedef struct packed {
        logic [31:0] instr;
        fmt_e        fmt;
    } entry_t;

    entry_t           enc_entry;
    entry_t           head;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    // Format is decided by the opcode alone; unused fields never reach the word.
    always_comb begin : encode
        enc_entry.fmt   = FMT_I;
        enc_entry.instr = {bus.opcode, bus.rs, bus.rt, bus.imm};
        case (bus.opcode)
            6'd0: begin
                enc_entry.fmt   = FMT_R;
                enc_entry.instr = {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
            end
            6'd2, 6'd3: begin
                enc_entry.fmt   = FMT_J;
                enc_entry.instr = {bus.opcode, bus.addr};
            end
            default: ;
        endcase
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin : status
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head  = mem_q[rd_ptr_q[AW-1:0]];
        push  = bus.in_valid && rst_n && !full;
        pop   = !empty && bus.out_ready;
    end

    assign bus.in_ready  = rst_n && !full;
    assign bus.out_valid = !empty;
    assign bus.instr     = empty ? 32'd0 : head.instr;
    assign bus.fmt       = empty ? 2'b00 : head.fmt;
    assign bus.count     = count_q;

    always_comb begin : next_state
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = enc_entry;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, backpressure, streaming,
// asynchronous reset and counter wrap on a narrow-counter instance.
module tb_instr_encoder;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   exp_count;

    instr_encoder_if #(.CNT_W(16)) bus ();
    instr_encoder_if #(.CNT_W(4))  bus4 ();

    instr_encoder #(.DEPTH(2), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    instr_encoder #(.DEPTH(2), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                 input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
                                 input logic [15:0] im, input logic [25:0] ad);
        bus.opcode   = op;
        bus.rs       = s;
        bus.rt       = t;
        bus.rd       = d;
        bus.shamt    = sh;
        bus.funct    = fn;
        bus.imm      = im;
        bus.addr     = ad;
        bus.in_valid = 1'b1;
    endtask

    // One word through an empty FIFO with out_ready high: visible after one edge, gone after the next.
    task automatic sendOne(input string tag, input logic [31:0] exp_instr, input logic [1:0] exp_fmt);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({tag, "_instr"}, bus.instr, exp_instr);
        checkOutput({tag, "_fmt"}, 32'(bus.fmt), 32'(exp_fmt));
        @(posedge clk); #1;
        exp_count++;
        checkOutput({tag, "_count"}, 32'(bus.count), 32'(exp_count));
        checkOutput({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_count = 0;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.opcode = '0; bus.funct = '0; bus.rs = '0; bus.rt = '0;
        bus.rd = '0; bus.shamt = '0; bus.imm = '0; bus.addr = '0;
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b0;
        bus4.opcode = '0; bus4.funct = '0; bus4.rs = '0; bus4.rt = '0;
        bus4.rd = '0; bus4.shamt = '0; bus4.imm = '0; bus4.addr = '0;

        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_instr", bus.instr, 32'd0);
        checkOutput("rst_fmt", 32'(bus.fmt), 32'd0);
        checkOutput("rst_count", 32'(bus.count), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("release_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        checkOutput("idle_out_valid", 32'(bus.out_valid), 32'd0);

        bus.out_ready = 1'b1;
        applyStimulus(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hBEEF, 26'h2AAAAAA);
        sendOne("r_add", 32'h00221820, 2'b00);
        applyStimulus(6'h23, 5'd29, 5'd8, 5'd17, 5'd9, 6'h3F, 16'h0010, 26'h1234567);
        sendOne("i_lw", 32'h8FA80010, 2'b01);
        applyStimulus(6'd3, 5'd7, 5'd7, 5'd7, 5'd7, 6'h11, 16'hFFFF, 26'h0000003);
        sendOne("j_jal", 32'h0C000003, 2'b10);
        applyStimulus(6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h3FFFFFF);
        sendOne("j_max", 32'h0BFFFFFF, 2'b10);

        bus.out_ready = 1'b0;
        applyStimulus(6'd8, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0);
        @(posedge clk); #1;
        checkOutput("bp_one_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("bp_one_instr", bus.instr, 32'h20221234);
        applyStimulus(6'd0, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'd0, 26'd0);
        @(posedge clk); #1;
        checkOutput("bp_full_ready", 32'(bus.in_ready), 32'd0);
        applyStimulus(6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h1555555);
        @(posedge clk); #1;
        checkOutput("bp_held_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("bp_held_instr", bus.instr, 32'h20221234);
        @(posedge clk); #1;
        checkOutput("bp_stable_instr", bus.instr, 32'h20221234);
        checkOutput("bp_stable_fmt", 32'(bus.fmt), 32'd1);
        checkOutput("bp_stable_count", 32'(bus.count), 32'd4);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_pop1_instr", bus.instr, 32'h03FFFFFF);
        checkOutput("bp_pop1_fmt", 32'(bus.fmt), 32'd0);
        checkOutput("bp_pop1_count", 32'(bus.count), 32'd5);
        checkOutput("bp_pop1_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checkOutput("bp_pop2_instr", bus.instr, 32'h09555555);
        checkOutput("bp_pop2_fmt", 32'(bus.fmt), 32'd2);
        checkOutput("bp_pop2_count", 32'(bus.count), 32'd6);
        @(posedge clk); #1;
        checkOutput("bp_done_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("bp_done_count", 32'(bus.count), 32'd7);

        bus.out_ready = 1'b0;
        applyStimulus(6'd8, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0);
        @(posedge clk); #1;
        applyStimulus(6'd0, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'd0, 26'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checkOutput("mid_buffered_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("mid_buffered_count", 32'(bus.count), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_rst_instr", bus.instr, 32'd0);
        checkOutput("mid_rst_fmt", 32'(bus.fmt), 32'd0);
        checkOutput("mid_rst_count", 32'(bus.count), 32'd0);
        checkOutput("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("mid_release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        checkOutput("mid_after_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("mid_after_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_after_count", 32'(bus.count), 32'd0);

        bus.out_ready = 1'b1;
        applyStimulus(6'h0F, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0100, 26'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("stream_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("stream_instr", bus.instr, 32'h3C000100 + 32'(i));
            checkOutput("stream_count", 32'(bus.count), 32'(i));
            checkOutput("stream_ready", 32'(bus.in_ready), 32'd1);
            if (i < 9) begin
                bus.imm = 16'h0100 + 16'(i + 1);
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        checkOutput("stream_end_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("stream_end_count", 32'(bus.count), 32'd10);

        bus4.out_ready = 1'b1;
        bus4.opcode = 6'h0F;
        bus4.imm = 16'd1;
        bus4.in_valid = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            bus4.imm = 16'(k + 1);
            if (k == 16) begin
                checkOutput("wrap_count_15", 32'(bus4.count), 32'd15);
            end
            if (k == 17) begin
                checkOutput("wrap_count_0", 32'(bus4.count), 32'd0);
                checkOutput("wrap_instr_17", bus4.instr, 32'h3C000011);
                bus4.in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        checkOutput("wrap_count_1", 32'(bus4.count), 32'd1);
        checkOutput("wrap_drained", 32'(bus4.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one parameter, DEPTH, default 2, meaning output buffer depth in entries (power of two, >= 2).
REQ-002 The block SHALL have one parameter, CNT_W, default 16, meaning emitted-instruction counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  field set on inputs is valid.
REQ-006 in_ready  output  1  block can accept a field set this cycle.
REQ-007 opcode  input  6  instruction opcode.
REQ-008 funct  input  6  R-type function code.
REQ-009 rs, rt, rd, shamt  input  5 each  register and shift-amount fields.
REQ-010 imm  input  16  I-type immediate.
REQ-011 addr  input  26  J-type target.
REQ-012 out_valid  output  1  instr/fmt hold a valid encoded word.
REQ-013 out_ready  input  1  consumer takes the word this cycle.
REQ-014 instr  output  32  encoded instruction word.
REQ-015 fmt  output  2  format of instr: 00 R, 01 I, 10 J; 11 never driven.
REQ-016 count  output  CNT_W  number of words delivered since reset.

Function
REQ-017 Format selection SHALL be: opcode==0 -> R; opcode==2 or 3 -> J; all other opcodes -> I.
REQ-018 The R word SHALL be {opcode,rs,rt,rd,shamt,funct}, the I word {opcode,rs,rt,imm}, and the J word {opcode,addr}; fields unused by the selected format SHALL be ignored.
REQ-019 A push SHALL occur on a rising edge with in_valid && in_ready; the encoded word and fmt SHALL be written into a DEPTH-entry FIFO.
REQ-020 A pop SHALL occur on a rising edge with out_valid && out_ready; count SHALL increment by 1 on each pop and wrap from 2^CNT_W-1 to 0.
REQ-021 in_ready SHALL be 1 iff rst_n==1 and the FIFO is not full; there is no push-through when full, even if a pop occurs in the same cycle.
REQ-022 out_valid SHALL be 1 iff the FIFO is non-empty; instr/fmt SHALL show the head entry and be 0 when empty.
REQ-023 Latency SHALL be one cycle: a word pushed at edge N into an empty FIFO is presented with out_valid=1 after edge N.
REQ-024 A simultaneous push and pop with occupancy between 1 and DEPTH-1 SHALL leave occupancy unchanged and preserve order.
REQ-025 While out_valid && !out_ready, instr and fmt SHALL hold stable.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer bit or an occupancy counter.
REQ-027 in_valid while in_ready==0 SHALL have no effect; the source holds fields until accepted.

Reset
REQ-028 rst_n low SHALL immediately (asynchronously) empty the FIFO and force out_valid=0, instr=0, fmt=00, count=0, in_ready=0.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered words; no partial pop or count update SHALL occur.
REQ-030 in_ready SHALL be 1 on the first cycle after rst_n deasserts.

Verification
REQ-031 R-type: opcode=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20, out_ready=1 -> next cycle instr=0x00221820, fmt=00, count=1 after the pop edge.
REQ-032 I-type: opcode=0x23, rs=29, rt=8, imm=0x0010 -> instr=0x8FA80010, fmt=01; J-type: opcode=3, addr=0x0000003 -> instr=0x0C000003, fmt=10.
REQ-033 Backpressure: out_ready=0, push 3 words with DEPTH=2 -> in_ready=0 after 2nd push, 3rd held; out_ready=1 -> words emerge in order, count=3.
REQ-034 Streaming: in_valid=out_ready=1 for 10 cycles with a distinct word each cycle -> one word out per cycle after the first, order preserved, count=10.
REQ-035 Reset mid-operation: 2 words buffered, pulse rst_n low between edges -> out_valid, instr, and count go to 0 immediately; in_ready=1 the cycle after release.
REQ-036 Wrap: CNT_W=4, deliver 17 words -> count=1.
